// File: rtl/com_pkg.sv
// Shared definitions for the com block: UART framing constants, receiver state
// encoding and the phase-accumulator tick arithmetic used by both directions.
`timescale 1ns/1ps
package com_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Wider accumulator at high clock rates keeps the tick-rate error small.
    function automatic int tick_acc_width(input longint clk_hz);
        return (clk_hz > 64'd50000000) ? 20 : 16;
    endfunction

    // Rounded increment so the accumulator carry fires at baud*oversampling Hz.
    function automatic longint tick_acc_inc(input longint clk_hz, input longint baud,
                                            input longint oversampling);
        int w;
        w = tick_acc_width(clk_hz);
        return (((baud * oversampling) << (w - 8)) + (clk_hz >> 9)) / (clk_hz >> 8);
    endfunction

endpackage

// File: rtl/baud_oversample_tick.sv
// Phase-accumulator sample-tick generator: one-clk SampleTick pulses at
// Baud*Oversampling Hz on average.
`timescale 1ns/1ps
module baud_oversample_tick
    import com_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic clk,
    input  logic rst,
    output logic SampleTick
);

    localparam int AccWidth = tick_acc_width(longint'(ClkFrequency));
    localparam logic [AccWidth-1:0] Inc =
        AccWidth'(tick_acc_inc(longint'(ClkFrequency), longint'(Baud), longint'(Oversampling)));

    logic [AccWidth:0] r_acc;
    logic              r_tick;

    // The carry out of the previous add is dropped on each step; it only drives the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_acc  <= {1'b0, r_acc[AccWidth-1:0]} + {1'b0, Inc};
            r_tick <= r_acc[AccWidth];
        end
    end

    assign SampleTick = r_tick;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first: oversampled, majority-filtered, mid-bit sampling,
// with one-clk data-ready and framing-error strobes.
`timescale 1ns/1ps
module uart_receiver
    import com_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RxD,
    output logic [UART_DATA_BITS-1:0] RxData,
    output logic                      RxDataReady,
    output logic                      RxFrameError,
    output logic                      RxBusy
);

    localparam int TW = $clog2(Oversampling);
    localparam logic [TW-1:0] TICK_HALF = TW'(Oversampling / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(Oversampling - 1);

    logic w_tick;

    baud_oversample_tick #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .SampleTick (w_tick)
    );

    logic [1:0] r_sync;
    logic [2:0] r_filt;
    logic       w_bit;

    // Presets of 1 keep a reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_filt <= 3'b111;
        end else begin
            r_sync <= {r_sync[0], RxD};
            if (w_tick)
                r_filt <= {r_filt[1:0], r_sync[1]};
        end
    end

    assign w_bit = (r_filt[0] & r_filt[1]) | (r_filt[0] & r_filt[2]) | (r_filt[1] & r_filt[2]);

    rx_state_t                 r_state, w_next;
    logic [TW-1:0]             r_tick_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_at_half, w_at_last;
    logic                      w_clr_cnt, w_sample, w_good_stop, w_bad_stop;

    assign w_at_half = w_tick && (r_tick_cnt == TICK_HALF);
    assign w_at_last = w_tick && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_tick && !w_bit) w_next = RX_START;
            RX_START: if (w_at_half) w_next = w_bit ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_at_last && (r_bit_cnt == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_at_last) w_next = w_bit ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (w_tick && w_bit) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_clr_cnt   = 1'b0;
        w_sample    = 1'b0;
        w_good_stop = 1'b0;
        w_bad_stop  = 1'b0;
        RxBusy      = 1'b0;
        case (r_state)
            RX_IDLE:  w_clr_cnt = w_tick && !w_bit;
            RX_START: begin
                RxBusy    = 1'b1;
                w_clr_cnt = w_at_half;
            end
            RX_DATA:  begin
                RxBusy   = 1'b1;
                w_sample = w_at_last;
            end
            RX_STOP:  begin
                RxBusy      = 1'b1;
                w_good_stop = w_at_last && w_bit;
                w_bad_stop  = w_at_last && !w_bit;
            end
            default: ;
        endcase
    end

    // Tick counter free-runs and wraps, so mid-bit points recur every Oversampling ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            RxData       <= '0;
            RxDataReady  <= 1'b0;
            RxFrameError <= 1'b0;
        end else begin
            RxDataReady  <= w_good_stop;
            RxFrameError <= w_bad_stop;
            if (w_clr_cnt) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_sample) begin
                r_shift   <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_good_stop)
                RxData <= r_shift;
        end
    end

endmodule
